// File: rtl/apb3_cmd_master.sv
// Turns a valid/ready command stream into single APB3 transfers and returns
// read data plus error/timeout status on a valid/ready response stream.
module apb3_cmd_master #(
  parameter int APB_ADDR_WIDTH_P   = 16,
  parameter int APB_DATA_WIDTH_P   = 32,
  parameter int APB_NR_OF_SLAVES_P = 4,
  parameter int TIMEOUT_P          = 16,
  localparam int SW = (APB_NR_OF_SLAVES_P > 1) ? $clog2(APB_NR_OF_SLAVES_P) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         cmd_valid,
  output logic                                         cmd_ready,
  input  logic                                         cmd_op,
  input  logic [SW-1:0]                                cmd_sel,
  input  logic [APB_ADDR_WIDTH_P-1:0]                  cmd_addr,
  input  logic [APB_DATA_WIDTH_P-1:0]                  cmd_wdata,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [APB_DATA_WIDTH_P-1:0]                  rsp_rdata,
  output logic                                         rsp_slverr,
  output logic                                         rsp_timeout,
  output logic [APB_NR_OF_SLAVES_P-1:0]                psel,
  output logic                                         penable,
  output logic                                         pwrite,
  output logic [APB_ADDR_WIDTH_P-1:0]                  paddr,
  output logic [APB_DATA_WIDTH_P-1:0]                  pwdata,
  input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] prdata,
  input  logic [APB_NR_OF_SLAVES_P-1:0]                pready,
  input  logic [APB_NR_OF_SLAVES_P-1:0]                pslverr
);

  localparam int CW = (TIMEOUT_P > 0) ? $clog2(TIMEOUT_P + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_P > 0) ? TIMEOUT_P - 1 : 0);

  // Handshakes: a beat transfers on a rising edge where valid && ready;
  // cmd_ready depends only on state, rsp fields are held while rsp_valid && !rsp_ready.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic                          op_q;
  logic [SW-1:0]                 sel_q;
  logic [APB_ADDR_WIDTH_P-1:0]   addr_q;
  logic [APB_DATA_WIDTH_P-1:0]   wdata_q;
  logic [APB_DATA_WIDTH_P-1:0]   rdata_q;
  logic                          slverr_q;
  logic                          timeout_q;
  logic [CW-1:0]                 tmo_cnt;

  logic [APB_NR_OF_SLAVES_P-1:0] sel_hot;
  logic                          pready_s;
  logic                          pslverr_s;
  logic [APB_DATA_WIDTH_P-1:0]   prdata_s;
  logic                          decode_ok;
  logic                          tmo_hit;

  assign decode_ok = (int'(cmd_sel) < APB_NR_OF_SLAVES_P);

  // Only the addressed completer's handshake and data are observed.
  always_comb begin
    sel_hot  = '0;
    prdata_s = '0;
    for (int i = 0; i < APB_NR_OF_SLAVES_P; i++) begin
      sel_hot[i] = (sel_q == SW'(i));
      if (sel_hot[i]) prdata_s = prdata[i*APB_DATA_WIDTH_P +: APB_DATA_WIDTH_P];
    end
    pready_s  = |(pready & sel_hot);
    pslverr_s = |(pslverr & sel_hot);
  end

  assign tmo_hit = (TIMEOUT_P > 0) && (tmo_cnt == TMO_LAST) && !pready_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = decode_ok ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready_s || tmo_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    penable   = (state == ACCESS);
    psel      = (state == SETUP || state == ACCESS) ? sel_hot : '0;
  end

  assign pwrite      = op_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sel_q <= cmd_sel;
            // A decode error leaves the bus fields untouched: no bus activity.
            if (decode_ok) begin
              op_q    <= cmd_op;
              addr_q  <= cmd_addr;
              wdata_q <= cmd_wdata;
            end else begin
              rdata_q   <= '0;
              slverr_q  <= 1'b1;
              timeout_q <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (pready_s) begin
            slverr_q  <= pslverr_s;
            rdata_q   <= (!op_q && !pslverr_s) ? prdata_s : '0;
            timeout_q <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q   <= '0;
            slverr_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else if (TIMEOUT_P > 0) begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: if (rsp_ready) tmo_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Randomised bench for apb3_cmd_master: a timeline model of each transfer is
// compared against the DUT every cycle, plus directed literal checks.
module tb_apb3_cmd_master;
  localparam int AW = 16, DW = 32, NS = 4, SW = 2, TMO = 16;

  // ---------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (4 completers)
  logic          cmd_valid = 0, cmd_op = 0, rsp_ready = 0;
  logic [SW-1:0] cmd_sel = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, penable, pwrite;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [AW-1:0] paddr;
  logic [NS-1:0] psel, pready, pslverr;
  logic [NS*DW-1:0] prdata;

  apb3_cmd_master #(.APB_ADDR_WIDTH_P(AW), .APB_DATA_WIDTH_P(DW),
                    .APB_NR_OF_SLAVES_P(NS), .TIMEOUT_P(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr));

  // ---------------- second DUT (3 completers, exercises decode error)
  logic          cmd_valid3 = 0, cmd_op3 = 0, rsp_ready3 = 0;
  logic [1:0]    cmd_sel3 = '0;
  logic [AW-1:0] cmd_addr3 = '0;
  logic [DW-1:0] cmd_wdata3 = '0;
  logic          cmd_ready3, rsp_valid3, rsp_slverr3, rsp_timeout3, penable3, pwrite3;
  logic [DW-1:0] rsp_rdata3, pwdata3;
  logic [AW-1:0] paddr3;
  logic [2:0]    psel3;
  logic [2:0]    pready3 = 3'b111, pslverr3 = 3'b000;
  logic [3*DW-1:0] prdata3 = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  apb3_cmd_master #(.APB_ADDR_WIDTH_P(AW), .APB_DATA_WIDTH_P(DW),
                    .APB_NR_OF_SLAVES_P(3), .TIMEOUT_P(TMO)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_sel(cmd_sel3), .cmd_addr(cmd_addr3), .cmd_wdata(cmd_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .rsp_slverr(rsp_slverr3), .rsp_timeout(rsp_timeout3), .psel(psel3),
    .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  // ---------------- scoreboard counters
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- completer model: selected slave ready after plan_w wait states
  int          plan_sel = 0, plan_w = 0;
  logic        plan_err = 0;
  logic [DW-1:0] plan_data = '0;
  int          acc_cnt = 0;
  logic [NS-1:0] nz_rdy = '0, nz_err = '0;
  logic [NS*DW-1:0] nz_data = '0;

  always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  initial forever begin
    @(negedge clk); #2;
    nz_rdy  = NS'($urandom);
    nz_err  = NS'($urandom);
    nz_data = {$urandom, $urandom, $urandom, $urandom};
  end

  always_comb begin
    pready  = nz_rdy;
    pslverr = nz_err;
    prdata  = nz_data;
    if (plan_sel >= 0 && plan_sel < NS) begin
      pready[plan_sel]            = (acc_cnt == plan_w);
      pslverr[plan_sel]           = plan_err;
      prdata[plan_sel*DW +: DW]   = plan_data;
    end
  end

  // ---------------- reference model: timeline of one transfer since acceptance
  // k=1 setup, k=2..A+1 access, k>=A+2 response (decode error: response from k=1).
  logic          m_busy = 0, m_dec = 0, m_err = 0, m_to = 0;
  int            m_k = 0, m_sel = 0, m_A = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [AW-1:0] last_addr = '0;
  logic          last_write = 0;
  logic [DW-1:0] last_wdata = '0;
  wire m_in_resp = m_busy && (m_dec ? (m_k >= 1) : (m_k >= m_A + 2));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_k <= 0;
      last_addr <= '0; last_write <= 0; last_wdata <= '0;
    end else if (m_busy) begin
      if (m_in_resp && rsp_ready) m_busy <= 0;
      else m_k <= m_k + 1;
    end else if (cmd_valid) begin
      m_busy <= 1; m_k <= 1;
      m_sel  <= int'(cmd_sel);
      m_dec  <= (int'(cmd_sel) >= NS);
      m_A    <= (plan_w >= TMO) ? TMO : plan_w + 1;
      if (int'(cmd_sel) >= NS) begin
        m_rdata <= '0; m_err <= 1; m_to <= 0;
      end else begin
        last_addr <= cmd_addr; last_write <= cmd_op; last_wdata <= cmd_wdata;
        if (plan_w >= TMO) begin
          m_rdata <= '0; m_err <= 1; m_to <= 1;
        end else begin
          m_rdata <= (!cmd_op && !plan_err) ? plan_data : '0;
          m_err <= plan_err; m_to <= 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    logic [NS-1:0] e_psel;
    logic e_pen, e_rdy, e_vld;
    e_psel = '0; e_pen = 0; e_rdy = 0; e_vld = 0;
    if (!rst_n || !m_busy) e_rdy = 1;
    else if (m_in_resp) e_vld = 1;
    else begin
      e_psel = NS'(1) << m_sel;
      e_pen  = (m_k >= 2);
    end
    chk("cmd_ready", cmd_ready, e_rdy);
    chk("psel", psel, e_psel);
    chk("penable", penable, e_pen);
    chk("rsp_valid", rsp_valid, e_vld);
    chk("paddr", paddr, last_addr);
    chk("pwrite", pwrite, last_write);
    chk("pwdata", pwdata, last_wdata);
    if (!rst_n) begin
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_slverr", rsp_slverr, 0);
      chk("rst_timeout", rsp_timeout, 0);
    end else if (e_vld) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_slverr", rsp_slverr, m_err);
      chk("rsp_timeout", rsp_timeout, m_to);
    end
  end

  // ---------------- driver
  task automatic send(input logic op, input int sel, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int w, input logic err,
                      input logic [DW-1:0] data, input int hold,
                      output int lat, output logic [NS-1:0] first_psel, output int pen_cnt,
                      output logic [DW-1:0] r_rdata, output logic r_err, output logic r_to,
                      output logic addr_ok);
    bit got;
    lat = 0; first_psel = '0; pen_cnt = 0; r_rdata = '0; r_err = 0; r_to = 0; addr_ok = 1;
    plan_sel = sel; plan_w = w; plan_err = err; plan_data = data;
    @(posedge clk); #1;
    cmd_op = op; cmd_sel = SW'(sel); cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; break; end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    cmd_op = 1'($urandom); cmd_sel = SW'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    got = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) first_psel = psel;
      if (penable) begin
        pen_cnt++;
        if (paddr !== addr) addr_ok = 0;
      end
      if (rsp_valid) begin lat = i; got = 1; break; end
    end
    if (!got) begin
      chk("rsp_timeout_wait", 0, 1);
      return;
    end
    r_rdata = rsp_rdata; r_err = rsp_slverr; r_to = rsp_timeout;
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  // ---------------- main sequence
  int lat, pen;
  logic [NS-1:0] fp;
  logic [DW-1:0] rd;
  logic re, rt, aok;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_psel", psel, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    @(posedge clk); #2 rst_n = 1;

    // zero-wait write to completer 2
    send(1, 2, 16'h0040, 32'hDEADBEEF, 0, 0, 32'h0BADF00D, 0, lat, fp, pen, rd, re, rt, aok);
    chk("wr_latency", lat, 3);
    chk("wr_setup_psel", fp, 4'b0100);
    chk("wr_access_cycles", pen, 1);
    chk("wr_slverr", re, 0);
    chk("wr_rdata", rd, 0);

    // read with 3 wait states
    send(0, 1, 16'h0010, 32'h0, 3, 0, 32'h12345678, 0, lat, fp, pen, rd, re, rt, aok);
    chk("rd_rdata", rd, 32'h12345678);
    chk("rd_access_cycles", pen, 4);
    chk("rd_paddr_stable", aok, 1);
    chk("rd_latency", lat, 6);

    // completer error on read
    send(0, 0, 16'h0020, 32'h0, 0, 1, 32'hFFFFFFFF, 0, lat, fp, pen, rd, re, rt, aok);
    chk("err_slverr", re, 1);
    chk("err_rdata", rd, 0);
    chk("err_timeout", rt, 0);

    // completer 3 never ready -> timeout after 16 access cycles
    send(0, 3, 16'h0030, 32'h0, 100, 0, 32'h55AA55AA, 0, lat, fp, pen, rd, re, rt, aok);
    chk("tmo_access_cycles", pen, 16);
    chk("tmo_timeout", rt, 1);
    chk("tmo_slverr", re, 1);
    chk("tmo_rdata", rd, 0);
    chk("tmo_latency", lat, 18);

    // next command after timeout, then ready exactly on the last allowed cycle
    send(1, 3, 16'h0034, 32'hA5A5A5A5, 0, 0, 32'h0, 0, lat, fp, pen, rd, re, rt, aok);
    chk("post_tmo_latency", lat, 3);
    chk("post_tmo_slverr", re, 0);
    send(0, 2, 16'h0044, 32'h0, 15, 0, 32'h600DCAFE, 0, lat, fp, pen, rd, re, rt, aok);
    chk("edge_access_cycles", pen, 16);
    chk("edge_timeout", rt, 0);
    chk("edge_rdata", rd, 32'h600DCAFE);

    // response backpressure for 5 cycles
    send(1, 0, 16'h0050, 32'h13572468, 1, 0, 32'h0, 5, lat, fp, pen, rd, re, rt, aok);
    chk("bp_latency", lat, 4);

    // reset during ACCESS
    plan_sel = 1; plan_w = 100; plan_err = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = 0; cmd_sel = 2'd1; cmd_addr = 16'h0060;
    @(negedge clk);
    chk("rst_pre_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_pre_penable", penable, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_psel", psel, 0);
    chk("rst_async_penable", penable, 0);
    chk("rst_async_cmd_ready", cmd_ready, 1);
    @(posedge clk); #3 rst_n = 1;
    @(negedge clk);
    chk("rst_release_cmd_ready", cmd_ready, 1);
    chk("rst_release_rsp_valid", rsp_valid, 0);
    send(0, 1, 16'h0064, 32'h0, 0, 0, 32'h89ABCDEF, 0, lat, fp, pen, rd, re, rt, aok);
    chk("rst_after_rdata", rd, 32'h89ABCDEF);

    // decode error on the 3-completer instance
    @(posedge clk); #1;
    cmd_valid3 = 1; cmd_sel3 = 2'd3; cmd_op3 = 0; cmd_addr3 = 16'h0123;
    @(negedge clk);
    chk("dec_cmd_ready", cmd_ready3, 1);
    @(posedge clk); #1 cmd_valid3 = 0;
    @(negedge clk);
    chk("dec_rsp_valid", rsp_valid3, 1);
    chk("dec_slverr", rsp_slverr3, 1);
    chk("dec_timeout", rsp_timeout3, 0);
    chk("dec_rdata", rsp_rdata3, 0);
    chk("dec_psel", psel3, 0);
    chk("dec_penable", penable3, 0);
    rsp_ready3 = 1;
    @(posedge clk); #1 rsp_ready3 = 0;
    @(negedge clk);
    chk("dec_idle_ready", cmd_ready3, 1);
    chk("dec_idle_valid", rsp_valid3, 0);
    @(posedge clk); #1;
    cmd_valid3 = 1; cmd_sel3 = 2'd2; cmd_op3 = 0; cmd_addr3 = 16'h0200;
    @(negedge clk);
    @(posedge clk); #1 cmd_valid3 = 0;
    @(negedge clk);
    chk("s3_setup_psel", psel3, 3'b100);
    chk("s3_setup_penable", penable3, 0);
    @(negedge clk);
    chk("s3_access_penable", penable3, 1);
    @(negedge clk);
    chk("s3_rsp_valid", rsp_valid3, 1);
    chk("s3_rdata", rsp_rdata3, 32'hCAFE0002);
    chk("s3_slverr", rsp_slverr3, 0);
    rsp_ready3 = 1;
    @(posedge clk); #1 rsp_ready3 = 0;

    // randomised traffic, checked by the per-cycle compare
    for (int n = 0; n < 60; n++) begin
      int r, w;
      r = $urandom_range(0, 9);
      w = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? 15 : (r == 8) ? 16 : 100;
      send(1'($urandom), $urandom_range(0, NS - 1), AW'($urandom), $urandom, w,
           1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3),
           lat, fp, pen, rd, re, rt, aok);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 500000", $time);
    $fatal(1);
  end

endmodule
